// File: rtl/keypad_debounce_encoder.sv
// keypad_debounce_encoder: synchronise and debounce raw pushbuttons into a stable vector, key code and press strobe
module keypad_debounce_encoder #(
    parameter int NUM_BTN         = 20,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NUM_BTN-1:0] buttons_raw,
    output logic [NUM_BTN-1:0] buttons_clean,
    output logic [4:0]         key_code,
    output logic               key_valid,
    output logic               key_strobe,
    output logic               multi_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t                               state_q;
    logic [SYNC_STAGES-1:0][NUM_BTN-1:0]  sync_q;
    logic [NUM_BTN-1:0]                   cand_q;
    logic [CW-1:0]                        cnt_q;
    logic [NUM_BTN-1:0]                   sync;
    logic [CW-1:0]                        cnt_inc;

    // Lowest set bit wins, so digits take precedence over function keys
    function automatic logic [4:0] lowest_idx(input logic [NUM_BTN-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--)
            if (v[i]) lowest_idx = 5'(i);
    endfunction

    assign sync    = sync_q[SYNC_STAGES-1];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    // Shift raw levels through the synchroniser chain; only the last stage is consumed
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], buttons_raw};
    end

    // Debounce FSM: a vector must hold steady to be accepted, and all-zero must hold steady to release
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            cand_q        <= '0;
            cnt_q         <= '0;
            buttons_clean <= '0;
            key_code      <= '0;
            key_valid     <= 1'b0;
            key_strobe    <= 1'b0;
            multi_press   <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync != '0) begin
                        cand_q  <= sync;
                        cnt_q   <= CW'(1);
                        state_q <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (sync == '0) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (sync != cand_q) begin
                        cand_q <= sync;
                        cnt_q  <= CW'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= HELD;
                        buttons_clean <= cand_q;
                        key_code      <= lowest_idx(cand_q);
                        key_valid     <= 1'b1;
                        key_strobe    <= 1'b1;
                        multi_press   <= |(cand_q & (cand_q - NUM_BTN'(1)));
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                HELD: begin
                    if (sync != cand_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= (sync == '0) ? CW'(1) : '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync == cand_q) begin
                        state_q <= HELD;
                    end else if (sync != '0) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                        buttons_clean <= '0;
                        key_code      <= '0;
                        key_valid     <= 1'b0;
                        multi_press   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// tb_keypad_debounce_encoder: directed and randomized checks of keypad_debounce_encoder against a run-length reference model
module tb_keypad_debounce_encoder;
    localparam int NUM_BTN     = 20;
    localparam int SYNC_STAGES = 2;
    localparam int DEB         = 16;
    localparam int LAT         = SYNC_STAGES + DEB;

    logic               clk = 1'b0;
    logic               nrst = 1'b0;
    logic [NUM_BTN-1:0] buttons_raw = '0;
    logic [NUM_BTN-1:0] buttons_clean;
    logic [4:0]         key_code;
    logic               key_valid;
    logic               key_strobe;
    logic               multi_press;
    int                 checks = 0;
    int                 errors = 0;

    keypad_debounce_encoder #(
        .NUM_BTN(NUM_BTN), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .nrst(nrst), .buttons_raw(buttons_raw), .buttons_clean(buttons_clean),
        .key_code(key_code), .key_valid(key_valid), .key_strobe(key_strobe), .multi_press(multi_press)
    );

    always #5 clk = ~clk;

    // Reference model: a press is accepted once the synchronised vector has been the same nonzero
    // value for DEB consecutive clocks; a release once it has been zero for DEB consecutive clocks.
    logic [NUM_BTN-1:0] m_pipe [SYNC_STAGES];
    logic [NUM_BTN-1:0] m_prev;
    int                 m_run;
    int                 m_run_n;
    logic               m_held;
    logic [NUM_BTN-1:0] e_clean;
    logic [4:0]         e_code;
    logic               e_valid;
    logic               e_strobe;
    logic               e_multi;
    wire [NUM_BTN-1:0]  m_s  = m_pipe[SYNC_STAGES-1];
    wire [NUM_BTN+7:0]  obs  = {buttons_clean, key_code, key_valid, key_strobe, multi_press};
    wire [NUM_BTN+7:0]  expv = {e_clean, e_code, e_valid, e_strobe, e_multi};

    function automatic logic [4:0] low_idx(input logic [NUM_BTN-1:0] v);
        for (int i = 0; i < NUM_BTN; i++)
            if (v[i]) return 5'(i);
        return 5'd0;
    endfunction

    always_comb m_run_n = (m_s == m_prev) ? m_run + 1 : 1;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] <= '0;
            m_prev   <= '0;
            m_run    <= 0;
            m_held   <= 1'b0;
            e_clean  <= '0;
            e_code   <= '0;
            e_valid  <= 1'b0;
            e_strobe <= 1'b0;
            e_multi  <= 1'b0;
        end else begin
            m_pipe[0] <= buttons_raw;
            for (int i = 1; i < SYNC_STAGES; i++) m_pipe[i] <= m_pipe[i-1];
            m_prev   <= m_s;
            m_run    <= m_run_n;
            e_strobe <= 1'b0;
            if (!m_held && m_s != '0 && m_run_n >= DEB) begin
                m_held   <= 1'b1;
                e_clean  <= m_s;
                e_code   <= low_idx(m_s);
                e_valid  <= 1'b1;
                e_strobe <= 1'b1;
                e_multi  <= $countones(m_s) > 1;
            end else if (m_held && m_s == '0 && m_run_n >= DEB) begin
                m_held  <= 1'b0;
                e_clean <= '0;
                e_code  <= '0;
                e_valid <= 1'b0;
                e_multi <= 1'b0;
            end
        end
    end

    task automatic test_reset();
        nrst = 1'b0;
        buttons_raw = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_state got %h want 0", obs); end
        nrst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== '0 || obs !== expv) begin errors++; $display("FAIL reset_exit cyc %0d got %h want 0", k, obs); end
        end
    endtask

    task automatic test_clean_press();
        int first = -1;
        int nstb = 0;
        int rel = -1;
        buttons_raw = NUM_BTN'(1) << 5;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL clean_press cyc %0d got %h want %h", k, obs, expv); end
            if (key_strobe) begin nstb++; if (first < 0) first = k; end
        end
        checks++;
        if (first != LAT || nstb != 1) begin errors++; $display("FAIL clean_strobe edge %0d count %0d want edge %0d count 1", first, nstb, LAT); end
        checks++;
        if (key_code !== 5'd5 || buttons_clean !== 20'h00020) begin errors++; $display("FAIL clean_held code %0d vec %h want 5 00020", key_code, buttons_clean); end
        buttons_raw = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL clean_release cyc %0d got %h want %h", k, obs, expv); end
            if (!key_valid && rel < 0) rel = k;
        end
        checks++;
        if (rel != LAT) begin errors++; $display("FAIL clean_release_edge got %0d want %0d", rel, LAT); end
    endtask

    task automatic test_bounce();
        int nstb = 0;
        int sawv = 0;
        int first = -1;
        for (int k = 0; k < 80; k++) begin
            buttons_raw = (k < 60 && (k / 4) % 2 == 0) ? NUM_BTN'(1) << 3 : '0;
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL bounce cyc %0d got %h want %h", k, obs, expv); end
            if (key_strobe) nstb++;
            if (key_valid) sawv++;
        end
        checks++;
        if (nstb != 0 || sawv != 0) begin errors++; $display("FAIL bounce_reject strobes %0d valid_cycles %0d want 0 0", nstb, sawv); end
        buttons_raw = NUM_BTN'(1) << 3;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL bounce_idle cyc %0d got %h want %h", k, obs, expv); end
            if (key_strobe && first < 0) first = k;
        end
        checks++;
        if (first != LAT) begin errors++; $display("FAIL bounce_idle_edge got %0d want %0d", first, LAT); end
        buttons_raw = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_bounce_then_hold();
        int nstb = 0;
        int at = -1;
        for (int k = 0; k < 50; k++) begin
            buttons_raw = (k < 3 || k >= 8) ? NUM_BTN'(1) << 12 : '0;
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL bounce_hold cyc %0d got %h want %h", k, obs, expv); end
            if (key_strobe) begin nstb++; at = k - 8 + 1; end
        end
        checks++;
        if (nstb != 1 || at != LAT || key_code !== 5'd12) begin errors++; $display("FAIL bounce_hold_strobe count %0d edge %0d code %0d want 1 %0d 12", nstb, at, key_code, LAT); end
        buttons_raw = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_multi();
        buttons_raw = (NUM_BTN'(1) << 16) | (NUM_BTN'(1) << 2);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL multi cyc %0d got %h want %h", k, obs, expv); end
        end
        checks++;
        if (key_code !== 5'd2 || multi_press !== 1'b1 || buttons_clean !== 20'h10004) begin
            errors++; $display("FAIL multi_held code %0d multi %b vec %h want 2 1 10004", key_code, multi_press, buttons_clean);
        end
        buttons_raw = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL multi_release cyc %0d got %h want %h", k, obs, expv); end
        end
        checks++;
        if (multi_press !== 1'b0 || key_valid !== 1'b0) begin errors++; $display("FAIL multi_cleared multi %b valid %b want 0 0", multi_press, key_valid); end
    endtask

    task automatic test_rollover();
        logic [NUM_BTN-1:0] pat [4];
        int want_stb [4];
        int nstb;
        pat[0] = NUM_BTN'(1) << 7; pat[1] = NUM_BTN'(1) << 8; pat[2] = '0; pat[3] = NUM_BTN'(1) << 8;
        want_stb[0] = 1; want_stb[1] = 0; want_stb[2] = 0; want_stb[3] = 1;
        for (int p = 0; p < 4; p++) begin
            nstb = 0;
            buttons_raw = pat[p];
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
                checks++;
                if (obs !== expv) begin errors++; $display("FAIL rollover ph %0d cyc %0d got %h want %h", p, k, obs, expv); end
                if (key_strobe) nstb++;
            end
            checks++;
            if (nstb != want_stb[p]) begin errors++; $display("FAIL rollover_strobes ph %0d got %0d want %0d", p, nstb, want_stb[p]); end
            if (p == 1) begin
                checks++;
                if (key_code !== 5'd7 || key_valid !== 1'b1) begin errors++; $display("FAIL rollover_code got %0d valid %b want 7 1", key_code, key_valid); end
            end
        end
        checks++;
        if (key_code !== 5'd8) begin errors++; $display("FAIL rollover_new_code got %0d want 8", key_code); end
        buttons_raw = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_midpress();
        int first;
        buttons_raw = NUM_BTN'(1) << 19;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL midreset_pre cyc %0d got %h want %h", k, obs, expv); end
        end
        nrst = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL midreset_async got %h want 0", obs); end
        @(negedge clk);
        nrst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            first = -1;
            for (int k = 1; k <= 25; k++) begin
                @(negedge clk);
                checks++;
                if (obs !== expv) begin errors++; $display("FAIL midreset_post r %0d cyc %0d got %h want %h", r, k, obs, expv); end
                if (key_strobe && first < 0) first = k;
            end
            checks++;
            if (first != LAT || key_code !== 5'd19) begin errors++; $display("FAIL midreset_strobe edge %0d code %0d want %0d 19", first, key_code, LAT); end
            nrst = 1'b0;
            #1;
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL held_reset_async got %h want 0", obs); end
            @(negedge clk);
            nrst = 1'b1;
        end
        buttons_raw = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_random();
        int hold = 0;
        logic [NUM_BTN-1:0] a;
        logic [NUM_BTN-1:0] b;
        for (int k = 0; k < 4000; k++) begin
            if (hold == 0) begin
                a = NUM_BTN'(1) << $urandom_range(0, NUM_BTN - 1);
                b = NUM_BTN'(1) << $urandom_range(0, NUM_BTN - 1);
                case ($urandom_range(0, 3))
                    0:       buttons_raw = '0;
                    1:       buttons_raw = a;
                    2:       buttons_raw = a | b;
                    default: buttons_raw = buttons_raw ^ a;
                endcase
                hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : int'($urandom_range(10, 40));
            end
            hold--;
            @(negedge clk);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL random cyc %0d raw %h got %h want %h", k, buttons_raw, obs, expv); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_bounce_then_hold();
        test_multi();
        test_rollover();
        test_reset_midpress();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
